// File: rtl/reorder_buffer.sv
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order retirement buffer with operand forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int DEPTH = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [5:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] rob_free_entry,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_data,
  input  logic [TAG_W-1:0] q_tag1,
  input  logic [TAG_W-1:0] q_tag2,
  output logic [32:0]      q_data1,
  output logic [32:0]      q_data2,
  output logic             commit_valid,
  output logic [5:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  input  logic             flush,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [5:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic do_alloc;
  logic do_wb;
  logic fwd1;
  logic fwd2;

  assign alloc_ready    = (count != FULL_COUNT);
  assign rob_free_entry = tail;
  assign do_alloc       = alloc_valid && alloc_ready;
  assign do_wb          = wb_valid && ent_valid[wb_tag];

  // Commit looks only at registered done, so a same-cycle writeback waits a cycle
  assign commit_valid = ent_valid[head] && ent_done[head];
  assign commit_rd    = ent_rd[head];
  assign commit_tag   = head;
  assign commit_data  = ent_data[head];

  assign fwd1 = wb_valid && (wb_tag == q_tag1) && ent_valid[q_tag1];
  assign fwd2 = wb_valid && (wb_tag == q_tag2) && ent_valid[q_tag2];

  assign q_data1 = fwd1 ? {1'b0, wb_data} :
                   (ent_valid[q_tag1] && ent_done[q_tag1]) ? {1'b0, ent_data[q_tag1]} :
                   {1'b1, 32'd0};
  assign q_data2 = fwd2 ? {1'b0, wb_data} :
                   (ent_valid[q_tag2] && ent_done[q_tag2]) ? {1'b0, ent_data[q_tag2]} :
                   {1'b1, 32'd0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      if (do_wb) begin
        ent_done[wb_tag] <= 1'b1;
      end
      // Retiring clears after the writeback so the head slot is freed cleanly
      if (commit_valid) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + 1'b1;
      end
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + 1'b1;
      end
      case ({do_alloc, commit_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; its contents only matter under a valid bit
  always_ff @(posedge clk) begin
    if (!flush && do_wb) begin
      ent_data[wb_tag] <= wb_data;
    end
    if (!flush && do_alloc) begin
      ent_rd[tail] <= alloc_rd;
    end
  end

endmodule

`default_nettype wire
